// File: rtl/min_max_pkg.sv
// min_max_pkg: shared state encoding and counter sizing for the min/max window block
package min_max_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/min_max_cmp.sv
// min_max_cmp: folds a new sample into a running low/high pair
module min_max_cmp #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] x,
  output logic [W-1:0] smaller,
  output logic [W-1:0] larger
);
  logic lt_lo, gt_hi;
  // strict compares keep the stored value on ties
  assign lt_lo   = SIGNED ? ($signed(x) < $signed(lo)) : (x < lo);
  assign gt_hi   = SIGNED ? ($signed(x) > $signed(hi)) : (x > hi);
  assign smaller = lt_lo ? x : lo;
  assign larger  = gt_hi ? x : hi;
endmodule

// File: rtl/min_max_window.sv
// min_max_window: min/max over fixed non-overlapping windows, result held on a valid/ready port
module min_max_window
  import min_max_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int WINDOW_LEN      = 4,
  parameter bit SIGNED_MODE     = 1'b0
) (
  input  logic                       Clk,
  input  logic                       nRst,
  input  logic [INPUT_BIT_WIDTH-1:0] InputData,
  input  logic                       InputValid,
  output logic                       InputReady,
  input  logic                       Clear,
  output logic [INPUT_BIT_WIDTH-1:0] OutMin,
  output logic [INPUT_BIT_WIDTH-1:0] OutMax,
  output logic                       OutValid,
  input  logic                       OutReady
);
  localparam int CW = cnt_width(WINDOW_LEN);
  localparam bit ONE = (WINDOW_LEN == 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [INPUT_BIT_WIDTH-1:0] wmin, wmax, wmin_nx, wmax_nx, cmin, cmax;
  logic accept, load;
  assign accept = InputValid && InputReady;
  min_max_cmp #(.W(INPUT_BIT_WIDTH), .SIGNED(SIGNED_MODE)) u_cmp (
    .lo(wmin), .hi(wmax), .x(InputData), .smaller(cmin), .larger(cmax)
  );
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wmin_nx  = wmin;
    wmax_nx  = wmax;
    load     = 1'b0;
    if (Clear) begin
      state_nx = ST_EMPTY;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        ST_EMPTY: if (accept) begin
          wmin_nx  = InputData;
          wmax_nx  = InputData;
          cnt_nx   = CW'(1);
          state_nx = ONE ? ST_HOLD : ST_ACCUM;
          load     = ONE;
        end
        ST_ACCUM: if (accept) begin
          wmin_nx = cmin;
          wmax_nx = cmax;
          cnt_nx  = cnt + CW'(1);
          if (cnt == CW'(WINDOW_LEN - 1)) begin
            state_nx = ST_HOLD;
            load     = 1'b1;
          end
        end
        ST_HOLD: if (OutReady) begin
          state_nx = ST_EMPTY;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = ST_EMPTY;
          cnt_nx   = '0;
        end
      endcase
    end
  end
  // ready and valid are registered decodes of the next state
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state      <= ST_EMPTY;
      cnt        <= '0;
      wmin       <= '0;
      wmax       <= '0;
      OutMin     <= '0;
      OutMax     <= '0;
      OutValid   <= 1'b0;
      InputReady <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      wmin       <= wmin_nx;
      wmax       <= wmax_nx;
      OutValid   <= (state_nx == ST_HOLD);
      InputReady <= (state_nx != ST_HOLD);
      if (load) begin
        OutMin <= wmin_nx;
        OutMax <= wmax_nx;
      end
    end
  end
endmodule

// File: doc/min_max_window.md
Name: min_max_window

Overview:
- Streaming downstream consumer for min/max comparison results.
- Accepts a valid/ready sample stream and tracks the running minimum and maximum over fixed, non-overlapping windows of WINDOW_LEN samples.
- Presents one {Min, Max} result per window on a valid/ready output port, then holds it until the consumer takes it.
- Sits after the pairwise comparator stage; feeds statistics/threshold logic.

Parameters:
- INPUT_BIT_WIDTH, 8, sample width in bits.
- WINDOW_LEN, 4, samples per window; legal range 1..65535.
- SIGNED_MODE, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- Clk  input  1  rising-edge clock.
- nRst  input  1  asynchronous active-low reset.
- InputData  input  INPUT_BIT_WIDTH  sample.
- InputValid  input  1  sample present.
- InputReady  output  1  block can accept a sample this cycle.
- Clear  input  1  synchronous discard of the partial window and any held result.
- OutMin  output  INPUT_BIT_WIDTH  window minimum.
- OutMax  output  INPUT_BIT_WIDTH  window maximum.
- OutValid  output  1  result held.
- OutReady  input  1  consumer takes the result.

Behaviour:
- One clock; reset is asynchronous and active-low.
- nRst low, effective immediately:
  - state = EMPTY, count = 0.
  - OutMin = 0, OutMax = 0, OutValid = 0.
  - InputReady = 0 while nRst is low; InputReady = 1 from the first edge after release.
- Accept condition: accept = InputValid && InputReady.
- InputReady = 1 in EMPTY and ACCUM, 0 in HOLD. It is a registered state decode, with no combinational path from OutReady.
- States and transitions:
  - EMPTY, accept: load min = max = InputData, count = 1. Go to ACCUM, or to HOLD if WINDOW_LEN == 1.
  - ACCUM, accept: min = smaller(min, InputData), max = larger(max, InputData), count += 1.
  - ACCUM, accept with count == WINDOW_LEN-1: update min/max including that sample, go to HOLD.
  - HOLD: OutValid = 1; OutMin/OutMax stable.
  - HOLD, OutReady = 1: next cycle OutValid = 0, state = EMPTY, count = 0.
- Latency: OutValid rises on the edge after the last sample of the window is accepted (1 cycle).
  - Minimum period per window = WINDOW_LEN + 1 cycles, when OutReady is held high.
- Working min/max are internal registers. OutMin/OutMax update only on entry to HOLD and keep their last value otherwise.
- Compare rules:
  - SIGNED_MODE selects signed or unsigned comparison.
  - On ties, the stored value is kept; the result is value-identical either way.
- Counter width = clog2(WINDOW_LEN+1). It never wraps, because it is reset on leaving HOLD.
- Clear (synchronous, highest priority after reset):
  - Next state EMPTY, count = 0, OutValid = 0.
  - A sample presented in the same cycle is dropped.
  - A held result is discarded even if OutReady = 1 in the same cycle, so the consumer must not count it.
  - OutMin/OutMax retain their values.
- InputValid in HOLD: the sample is not accepted and the upstream must hold it.
- nRst asserted mid-window or in HOLD: everything returns to reset values and the partial result is lost.
- X on InputData while InputValid = 0 must not propagate to state.

Decomposition:
- Shared package min_max_pkg:
  - State encoding constants: ST_EMPTY = 2'd0, ST_ACCUM = 2'd1, ST_HOLD = 2'd2.
  - Localparam helper for counter width.
- One natural sub-module: min_max_cmp.
  - Combinational, parameterised width and signedness.
  - Returns smaller/larger of two operands.
  - Instantiated once for the working-register update.
- Top-level min_max_window holds the FSM, counter, handshake and registers.

Test Plan:
- Reset/idle: nRst low 3 cycles, then release → OutValid = 0, OutMin = OutMax = 0, InputReady = 1 on the first cycle after release.
- Basic window, WINDOW_LEN = 4, unsigned, OutReady = 1, samples 5, 200, 17, 9 back-to-back → OutMin = 5, OutMax = 200, OutValid high exactly 1 cycle after the 4th accept. The next window accepts from the following cycle.
- Back-pressure: OutReady = 0 for 6 cycles after OutValid while InputValid = 1 with data 3 → InputReady stays 0, result stays 5/200, no sample lost. The sample 3 is accepted first once OutReady pulses.
- Signed, SIGNED_MODE = 1, width 8, samples 0x7F, 0x80, 0x00, 0xFF → OutMin = 0x80 (-128), OutMax = 0x7F (127).
- Clear mid-window: accept 10, 20, assert Clear with InputValid = 1 and data 99, then feed 1, 2, 3, 4 → result 1/4. 99 is never reflected.
- Edge cases:
  - WINDOW_LEN = 1, samples 42, 7 with OutReady = 1 → two results, 42/42 then 7/7.
  - nRst asserted while in HOLD → OutValid drops asynchronously and the bench expects no result.
